// File: rtl/exec_mem_unit.sv
// exec_mem_unit: execute/memory stage of the 8-bit ExceptioNull CPU.
// Decodes one instruction per valid cycle, runs the 8-bit ALU, accesses a
// MEM_DEPTH x 8 data memory, and returns registered write-back, branch and
// status one cycle later.
//
// Optional feature macro: ALU_MUL_EN (opcode 1011 becomes unsigned multiply).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   valid_in          instruction/operands valid this cycle
//   instruction       [7:4] opcode, [3:2] field A, [1:0] field B
//   pc                address of the current instruction
//   in0, in1          register[field A], register[field B]
//   jump_offset       register 0, branch offset for beq/bne
//   reg_addr_0/1      combinational register-file read addresses
//   valid_out         registered result valid
//   reg_w_en          registered write-back enable
//   reg_addr_w        registered destination register
//   wb_data           registered write-back value
//   branch, target    registered PC redirect and its address
//   overflow          registered signed overflow (add/sub, or mul high byte)
//   mem_r_en/mem_w_en registered memory access indicators
module exec_mem_unit #(
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned JAL_LINK_REG = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] instruction,
  input  logic [7:0] pc,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] jump_offset,
  output logic [1:0] reg_addr_0,
  output logic [1:0] reg_addr_1,
  output logic       valid_out,
  output logic       reg_w_en,
  output logic [1:0] reg_addr_w,
  output logic [7:0] wb_data,
  output logic       branch,
  output logic [7:0] target,
  output logic       overflow,
  output logic       mem_r_en,
  output logic       mem_w_en
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
    OP_XOR = 4'b0100, OP_NOR = 4'b0101, OP_SLT = 4'b0110, OP_SLL = 4'b0111,
    OP_SRL = 4'b1000, OP_LW  = 4'b1001, OP_SW  = 4'b1010, OP_RSV = 4'b1011,
    OP_BEQ = 4'b1100, OP_BNE = 4'b1101, OP_J   = 4'b1110, OP_JAL = 4'b1111
  } opcode_e;

  opcode_e       opcode;
  logic [DW-1:0] sum, diff, pc_inc, br_tgt;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] alu_d;
  logic          wen_d, br_d, ovf_d, mr_d, mw_d;
  logic [1:0]    addr_w_d;
  logic [DW-1:0] tgt_d;

  logic          valid_q, reg_w_en_q, branch_q, overflow_q, mem_r_en_q, mem_w_en_q;
  logic [1:0]    reg_addr_w_q;
  logic [DW-1:0] wb_data_q, target_q;
  logic [DW-1:0] mem_q [MEM_DEPTH];

`ifdef ALU_MUL_EN
  logic [2*DW-1:0] prod;
  assign prod = (2*DW)'(in0) * (2*DW)'(in1);
`endif

  assign opcode     = opcode_e'(instruction[7:4]);
  assign reg_addr_0 = instruction[3:2];
  assign reg_addr_1 = instruction[1:0];
  assign sum        = in0 + in1;
  assign diff       = in0 - in1;
  assign pc_inc     = pc + 8'd1;
  assign br_tgt     = pc_inc + jump_offset;
  // Operand wraps modulo the memory depth (identity for a 256-word memory).
  assign mem_addr   = AW'(32'(in1) % MEM_DEPTH);

  // Decode and ALU: next values for every registered output.
  always_comb begin
    alu_d    = '0;
    wen_d    = 1'b0;
    addr_w_d = instruction[3:2];
    br_d     = 1'b0;
    tgt_d    = '0;
    ovf_d    = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_d = sum;
        wen_d = 1'b1;
        ovf_d = (in0[7] == in1[7]) && (sum[7] != in0[7]);
      end
      OP_SUB: begin
        alu_d = diff;
        wen_d = 1'b1;
        ovf_d = (in0[7] != in1[7]) && (diff[7] != in0[7]);
      end
      OP_AND: begin alu_d = in0 & in1;    wen_d = 1'b1; end
      OP_OR:  begin alu_d = in0 | in1;    wen_d = 1'b1; end
      OP_XOR: begin alu_d = in0 ^ in1;    wen_d = 1'b1; end
      OP_NOR: begin alu_d = ~(in0 | in1); wen_d = 1'b1; end
      OP_SLT: begin
        alu_d = DW'($signed(in0) < $signed(in1));
        wen_d = 1'b1;
      end
      OP_SLL: begin alu_d = in0 << in1[2:0]; wen_d = 1'b1; end
      OP_SRL: begin alu_d = in0 >> in1[2:0]; wen_d = 1'b1; end
      OP_LW:  begin wen_d = 1'b1; mr_d = 1'b1; end
      OP_SW:  mw_d = 1'b1;
`ifdef ALU_MUL_EN
      OP_RSV: begin
        alu_d = prod[DW-1:0];
        wen_d = 1'b1;
        ovf_d = |prod[2*DW-1:DW];
      end
`else
      OP_RSV: ;
`endif
      OP_BEQ: begin
        br_d  = (in0 == in1);
        tgt_d = br_d ? br_tgt : '0;
      end
      OP_BNE: begin
        br_d  = (in0 != in1);
        tgt_d = br_d ? br_tgt : '0;
      end
      OP_J: begin
        br_d  = 1'b1;
        tgt_d = in0;
      end
      OP_JAL: begin
        br_d     = 1'b1;
        tgt_d    = in0;
        alu_d    = pc_inc;
        wen_d    = 1'b1;
        addr_w_d = 2'(JAL_LINK_REG);
      end
      default: ;
    endcase
  end

  // Result registers and data memory; read happens before the same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_w_en_q   <= 1'b0;
      reg_addr_w_q <= '0;
      wb_data_q    <= '0;
      branch_q     <= 1'b0;
      target_q     <= '0;
      overflow_q   <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        reg_w_en_q   <= wen_d;
        reg_addr_w_q <= addr_w_d;
        branch_q     <= br_d;
        target_q     <= tgt_d;
        overflow_q   <= ovf_d;
        mem_r_en_q   <= mr_d;
        mem_w_en_q   <= mw_d;
        if (mr_d)       wb_data_q <= mem_q[mem_addr];
        else if (wen_d) wb_data_q <= alu_d;
        if (mw_d)       mem_q[mem_addr] <= in0;
      end else begin
        reg_w_en_q <= 1'b0;
        branch_q   <= 1'b0;
        overflow_q <= 1'b0;
        mem_r_en_q <= 1'b0;
        mem_w_en_q <= 1'b0;
      end
    end
  end

  assign valid_out  = valid_q;
  assign reg_w_en   = reg_w_en_q;
  assign reg_addr_w = reg_addr_w_q;
  assign wb_data    = wb_data_q;
  assign branch     = branch_q;
  assign target     = target_q;
  assign overflow   = overflow_q;
  assign mem_r_en   = mem_r_en_q;
  assign mem_w_en   = mem_w_en_q;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: hand-computed vectors, one step per cycle.
module tb_exec_mem_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] instruction, pc, in0, in1, jump_offset;
  logic [1:0] reg_addr_0, reg_addr_1, reg_addr_w;
  logic       valid_out, reg_w_en, branch, overflow, mem_r_en, mem_w_en;
  logic [7:0] wb_data, target;

  int n_pass = 0;
  int n_chk  = 0;

  exec_mem_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instruction(instruction),
    .pc(pc), .in0(in0), .in1(in1), .jump_offset(jump_offset),
    .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1),
    .valid_out(valid_out), .reg_w_en(reg_w_en), .reg_addr_w(reg_addr_w),
    .wb_data(wb_data), .branch(branch), .target(target),
    .overflow(overflow), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one instruction, clock it in, and settle just after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] ins,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] p, input logic [7:0] jo);
    rst = r; valid_in = v; instruction = ins;
    in0 = a; in1 = b; pc = p; jump_offset = jo;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; instruction = '0;
    in0 = '0; in1 = '0; pc = '0; jump_offset = '0;
    #1;
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst_valid_out", 8'(valid_out), 8'h00);
    chk("rst_wb_data",   wb_data,       8'h00);
    chk("rst_target",    target,        8'h00);

    // Store 0x5A at 0x10 and read it back to show memory works.
    step(1'b0, 1'b1, 8'hA0, 8'h5A, 8'h10, 8'h00, 8'h00);
    chk("sw_mem_w_en", 8'(mem_w_en), 8'h01);
    step(1'b0, 1'b1, 8'h94, 8'h00, 8'h10, 8'h00, 8'h00);
    chk("lw_pre_rst", wb_data, 8'h5A);

    // Reset with a store pending: outputs clear, memory clears, store dropped.
    step(1'b1, 1'b1, 8'hA0, 8'h77, 8'h10, 8'h00, 8'h00);
    chk("rst_sw_valid_out", 8'(valid_out), 8'h00);
    chk("rst_sw_mem_w_en",  8'(mem_w_en),  8'h00);
    chk("rst_sw_reg_w_en",  8'(reg_w_en),  8'h00);
    chk("rst_sw_wb_data",   wb_data,       8'h00);
    step(1'b0, 1'b1, 8'h94, 8'h00, 8'h10, 8'h00, 8'h00);
    chk("lw_post_rst",  wb_data,        8'h00);
    chk("lw_post_rst_r", 8'(mem_r_en),  8'h01);
    chk("lw_post_rst_a", 8'(reg_addr_w), 8'h01);

    // Combinational read addresses.
    instruction = 8'h9E;
    #1;
    chk("reg_addr_0", 8'(reg_addr_0), 8'h03);
    chk("reg_addr_1", 8'(reg_addr_1), 8'h02);

    // add with signed overflow, then sub without.
    step(1'b0, 1'b1, 8'h01, 8'h7F, 8'h01, 8'h00, 8'h00);
    chk("add_wb",    wb_data,          8'h80);
    chk("add_ovf",   8'(overflow),     8'h01);
    chk("add_rd",    8'(reg_addr_w),   8'h00);
    chk("add_wen",   8'(reg_w_en),     8'h01);
    chk("add_valid", 8'(valid_out),    8'h01);
    step(1'b0, 1'b1, 8'h10, 8'h05, 8'h07, 8'h00, 8'h00);
    chk("sub_wb",  wb_data,      8'hFE);
    chk("sub_ovf", 8'(overflow), 8'h00);

    // Store then load on the next cycle.
    step(1'b0, 1'b1, 8'hA0, 8'hA5, 8'h3C, 8'h00, 8'h00);
    chk("sw_wen",  8'(reg_w_en), 8'h00);
    chk("sw_wr",   8'(mem_w_en), 8'h01);
    step(1'b0, 1'b1, 8'h98, 8'h00, 8'h3C, 8'h00, 8'h00);
    chk("lw_wb",  wb_data,         8'hA5);
    chk("lw_rd",  8'(mem_r_en),    8'h01);
    chk("lw_rdw", 8'(reg_addr_w),  8'h02);
    chk("lw_wr",  8'(mem_w_en),    8'h00);

    // beq taken with wrapping target, bne not taken.
    step(1'b0, 1'b1, 8'hC1, 8'h22, 8'h22, 8'hF0, 8'h20);
    chk("beq_br",  8'(branch),   8'h01);
    chk("beq_tgt", target,       8'h11);
    chk("beq_wen", 8'(reg_w_en), 8'h00);
    step(1'b0, 1'b1, 8'hD1, 8'h22, 8'h22, 8'hF0, 8'h20);
    chk("bne_br",  8'(branch), 8'h00);
    chk("bne_tgt", target,     8'h00);

    // jal writes pc+1 to the link register.
    step(1'b0, 1'b1, 8'hF4, 8'h40, 8'h00, 8'h09, 8'h00);
    chk("jal_br",  8'(branch),     8'h01);
    chk("jal_tgt", target,         8'h40);
    chk("jal_wen", 8'(reg_w_en),   8'h01);
    chk("jal_rd",  8'(reg_addr_w), 8'h03);
    chk("jal_wb",  wb_data,        8'h0A);

    // Bubble: flags drop, wb_data and target hold.
    step(1'b0, 1'b0, 8'h01, 8'h7F, 8'h01, 8'h00, 8'h00);
    chk("idle_valid", 8'(valid_out), 8'h00);
    chk("idle_br",    8'(branch),    8'h00);
    chk("idle_wen",   8'(reg_w_en),  8'h00);
    chk("idle_ovf",   8'(overflow),  8'h00);
    chk("idle_tgt",   target,        8'h40);
    chk("idle_wb",    wb_data,       8'h0A);

    // Shifts, logic and slt.
    step(1'b0, 1'b1, 8'h70, 8'h81, 8'h0B, 8'h00, 8'h00);
    chk("sll_wb", wb_data, 8'h08);
    step(1'b0, 1'b1, 8'h80, 8'h81, 8'h01, 8'h00, 8'h00);
    chk("srl_wb", wb_data, 8'h40);
    step(1'b0, 1'b1, 8'h60, 8'hFF, 8'h01, 8'h00, 8'h00);
    chk("slt_wb", wb_data, 8'h01);
    step(1'b0, 1'b1, 8'h60, 8'h01, 8'hFF, 8'h00, 8'h00);
    chk("slt_wb0", wb_data, 8'h00);
    step(1'b0, 1'b1, 8'h20, 8'hF0, 8'h3C, 8'h00, 8'h00);
    chk("and_wb", wb_data, 8'h30);
    step(1'b0, 1'b1, 8'h50, 8'h0F, 8'hF0, 8'h00, 8'h00);
    chk("nor_wb", wb_data, 8'h00);
    step(1'b0, 1'b1, 8'h40, 8'h0F, 8'hFF, 8'h00, 8'h00);
    chk("xor_wb", wb_data, 8'hF0);

    // Opcode 1011.
    step(1'b0, 1'b1, 8'hB0, 8'h10, 8'h20, 8'h00, 8'h00);
    chk("op11_valid", 8'(valid_out), 8'h01);
`ifdef ALU_MUL_EN
    chk("mul_wb",  wb_data,      8'h00);
    chk("mul_ovf", 8'(overflow), 8'h01);
    chk("mul_wen", 8'(reg_w_en), 8'h01);
`else
    chk("nop_wen", 8'(reg_w_en), 8'h00);
    chk("nop_ovf", 8'(overflow), 8'h00);
    chk("nop_wb",  wb_data,      8'hF0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
- Execute/memory stage of the 8-bit ExceptioNull CPU: instruction decode (control), 8-bit ALU, and a 256x8 data memory in one clocked block.
- The CPU owns the 4x8 register file and the PC; this block receives the instruction and operand values, and returns write-back data, branch redirect and status.
- Single issue, one result per valid instruction, 1-cycle latency.

Parameters:
- MEM_DEPTH, 256, data memory words of 8 bits; address is operand modulo MEM_DEPTH.
- JAL_LINK_REG, 3, register index written by jal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  instruction/operands valid this cycle
- instruction  in  8  [7:4] opcode, [3:2] field A (rd/rs0), [1:0] field B (rs1)
- pc  in  8  address of current instruction
- in0  in  8  value of register[field A]
- in1  in  8  value of register[field B]
- jump_offset  in  8  value of register 0 (branch offset)
- reg_addr_0  out  2  combinational = instruction[3:2]
- reg_addr_1  out  2  combinational = instruction[1:0]
- valid_out  out  1  registered, result valid
- reg_w_en  out  1  registered, write-back enable
- reg_addr_w  out  2  registered, destination register
- wb_data  out  8  registered, write-back value
- branch  out  1  registered, PC redirect taken
- target  out  8  registered, redirect address (0 when branch=0)
- overflow  out  1  registered, signed overflow of add/sub
- mem_r_en, mem_w_en  out  1 each  registered, memory access performed

Behaviour:
- Reset: on rst at clk edge all registered outputs go to 0 and all memory words clear to 0. rst takes priority over valid_in; an instruction presented in the reset cycle is discarded.
- Latency: an instruction accepted at edge N has its outputs valid after edge N. valid_out = valid_in delayed one cycle.
- When valid_in=0: valid_out=0, reg_w_en, branch, mem_*_en and overflow are 0, wb_data and target hold.
- Opcode map, A=in0, B=in1, all results mod 256. Write-back goes to field A unless noted:
  - 0000 add: A+B
  - 0001 sub: A-B
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 nor
  - 0110 slt: 1 if signed A<B, else 0
  - 0111 sll: A<<B[2:0]
  - 1000 srl: A>>B[2:0], logical
  - 1001 lw: rd=A field, data = mem[B]; mem_r_en=1
  - 1010 sw: mem[B] <= A at the accepting edge; reg_w_en=0; mem_w_en=1
  - 1011 reserved (see optional feature): reg_w_en=0, no effect
  - 1100 beq: branch = (A==B)
  - 1101 bne: branch = (A!=B)
  - 1110 j: branch=1, target=A
  - 1111 jal: branch=1, target=A; writes pc+1 to JAL_LINK_REG
- Branch target for beq and bne is pc+1+jump_offset, wrapping mod 256. Branch opcodes have reg_w_en=0 except jal.
- overflow is set only for add/sub on two's-complement signed overflow; it is 0 for all other opcodes.
- Memory read is synchronous, read-before-write. lw data comes from memory state before the accepting edge. sw followed next cycle by lw to the same address returns the new value.
- Address wraps when MEM_DEPTH < 256: address = B mod MEM_DEPTH.

Optional Feature:
- ALU_MUL_EN defined: opcode 1011 = mul. wb_data = low 8 bits of A*B (unsigned), reg_w_en=1. overflow=1 when the high 8 bits are nonzero.
- ALU_MUL_EN undefined: 1011 is a no-op with valid_out=1, reg_w_en=0, overflow=0.

Test Plan:
- Reset: assert rst with valid_in=1 and sw pending, then run lw from address 0x10. Expected: all outputs 0 after reset, lw returns 0x00, store dropped.
- Add overflow: instruction 0x01, in0=0x7F, in1=0x01. Expected next cycle: wb_data=0x80, overflow=1, reg_addr_w=0, reg_w_en=1. Sub with in0=0x05, in1=0x07 gives wb_data=0xFE, overflow=0.
- Store then load: sw with A=0xA5, B=0x3C, then lw into reg 2 with B=0x3C on the next cycle. Expected: lw gives wb_data=0xA5, mem_r_en=1, reg_addr_w=2.
- Branches: beq with in0=in1=0x22, pc=0xF0, jump_offset=0x20. Expected: branch=1, target=0x11 (wrap). bne with the same operands gives branch=0, target=0.
- jal: instruction 0xF4, in0=0x40, pc=0x09. Expected: branch=1, target=0x40, reg_w_en=1, reg_addr_w=3, wb_data=0x0A.
- Shifts and slt: sll with A=0x81, B=0x0B (shift 3) gives 0x08. slt with A=0xFF, B=0x01 gives 0x01. Opcode 1011 with A=0x10, B=0x20 gives 0x00 and overflow=1 when ALU_MUL_EN is defined, and reg_w_en=0 otherwise.
